// File: rtl/arriskv_pkg.sv
// Shared arriskv core types: decoded instruction encoding plus the load/store unit's
// state, exception and access-size enums and small decode helpers.
package arriskv_pkg;

  typedef enum logic [4:0] {
    INSTR_NOP, INSTR_ADD,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW
  } instr_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_t;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN = 2'd0,
    EXC_ST_MISALIGN = 2'd1,
    EXC_BUS_TIMEOUT = 2'd2
  } lsu_exc_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} lsu_size_t;

  function automatic logic is_load(instr_t i);
    return (i == INSTR_LB) || (i == INSTR_LH) || (i == INSTR_LW) ||
           (i == INSTR_LBU) || (i == INSTR_LHU);
  endfunction

  function automatic logic is_store(instr_t i);
    return (i == INSTR_SB) || (i == INSTR_SH) || (i == INSTR_SW);
  endfunction

  function automatic logic is_unsigned(instr_t i);
    return (i == INSTR_LBU) || (i == INSTR_LHU);
  endfunction

  function automatic lsu_size_t lsu_size(instr_t i);
    case (i)
      INSTR_LB, INSTR_LBU, INSTR_SB: return BYTE;
      INSTR_LH, INSTR_LHU, INSTR_SH: return HALF;
      default:                       return WORD;
    endcase
  endfunction

  function automatic logic misaligned(lsu_size_t s, logic [1:0] off);
    case (s)
      HALF:    return off[0];
      WORD:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arriskv_lsu_align.sv
// Purely combinational lane logic: byte-enable generation, store-data replication,
// and load lane extraction with sign/zero extension.
module arriskv_lsu_align
  import arriskv_pkg::*;
(
  input  lsu_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    be_o         = 4'b1111;
    store_data_o = wdata_i;
    load_data_o  = shifted;
    case (size_i)
      BYTE: begin
        be_o         = 4'b0001 << offset_i;
        store_data_o = {4{wdata_i[7:0]}};
        load_data_o  = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
      end
      HALF: begin
        be_o         = 4'b0011 << offset_i;
        store_data_o = {2{wdata_i[15:0]}};
        load_data_o  = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arriskv_lsu.sv
// Load/store unit controller: accepts one load/store from execute, runs the
// req/gnt/rvalid data-memory handshake and returns extended load data or an exception.
module arriskv_lsu
  import arriskv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  instr_t          instr,
  input  logic [4:0]      rdest,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rdest,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic [1:0]      exc_cause,
  output logic [XLEN-1:0] exc_addr
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  instr_t      instr_q;
  logic [4:0]  rdest_q, wb_rdest_q;
  logic [31:0] addr_q, wdata_q, wb_data_q, exc_addr_q;
  logic [7:0]  cnt_q;
  logic        wb_valid_q, exc_valid_q;
  logic [1:0]  exc_cause_q;

  logic        accept, acc_misal;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign accept    = op_valid && (state_q == IDLE) && (is_load(instr) || is_store(instr));
  assign acc_misal = misaligned(lsu_size(instr), addr[1:0]);

  arriskv_lsu_align u_align (
    .size_i      (lsu_size(instr_q)),
    .unsigned_i  (is_unsigned(instr_q)),
    .offset_i    (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .be_o        (lane_be),
    .store_data_o(lane_wdata),
    .load_data_o (lane_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && !acc_misal) state_d = REQ;
      REQ:      if (mem_gnt) state_d = is_store(instr_q) ? IDLE : WAIT_RSP;
      WAIT_RSP: if (mem_rvalid || (cnt_q == TimeoutLast)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state_q == IDLE);
    mem_req   = (state_q == REQ);
    mem_we    = mem_req && is_store(instr_q);
    mem_be    = mem_req ? lane_be : 4'b0000;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = mem_we ? lane_wdata : '0;
    wb_valid  = wb_valid_q;
    wb_rdest  = wb_rdest_q;
    wb_data   = wb_data_q;
    exc_valid = exc_valid_q;
    exc_cause = exc_cause_q;
    exc_addr  = exc_addr_q;
  end

  // Late rvalid after a timeout is ignored simply because the FSM is no longer in WAIT_RSP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q     <= INSTR_NOP;
      rdest_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rdest_q  <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          instr_q <= instr;
          rdest_q <= rdest;
          addr_q  <= addr;
          wdata_q <= wdata;
          if (acc_misal) begin
            exc_valid_q <= 1'b1;
            exc_cause_q <= is_store(instr) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            exc_addr_q  <= addr;
          end
        end
        REQ: if (mem_gnt) cnt_q <= '0;
        WAIT_RSP: begin
          if (mem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_rdest_q <= rdest_q;
            wb_data_q  <= lane_load;
          end else if (cnt_q == TimeoutLast) begin
            exc_valid_q <= 1'b1;
            exc_cause_q <= EXC_BUS_TIMEOUT;
            exc_addr_q  <= addr_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
